tx_frame_scheduler: RTL and testbench

- Round-robin scheduler that shares one serial transmitter between NUM_REQ requesters.
- Accepts one byte from the winning requester, computes its parity bit and issues a single-cycle Send pulse to the transmitter.
- Blocks further grants for the full frame time, then releases the transmitter.
- Sits between the byte producers and the Tx shift-register block; owns all Send timing.

---
 rtl/tx_frame_scheduler_if.sv | 28 ++
 rtl/tx_frame_scheduler.sv | 147 ++++++++++++++
 tb/tb_tx_frame_scheduler.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_frame_scheduler_if.sv
// Requester/transmitter bundle for tx_frame_scheduler.
// The master side drives the requests; the slave side is the scheduler.
interface tx_frame_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic [ID_W-1:0]           grant_id;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_parity;
    logic                      tx_send;
    logic                      busy;
    logic                      frame_done;

    modport master (
        output req, req_data,
        input  ack, grant_id, tx_data, tx_parity, tx_send, busy, frame_done
    );

    modport slave (
        input  req, req_data,
        output ack, grant_id, tx_data, tx_parity, tx_send, busy, frame_done
    );
endinterface

// File: rtl/tx_frame_scheduler.sv
// Round-robin arbiter sharing one serial transmitter between NUM_REQ producers.
// Grants one byte, pulses Send once, then holds the transmitter for FRAME_CYC cycles.
//
// state | meaning
// IDLE  | sampling requests, next grant chosen round-robin after ptr_q
// GRANT | ack pulse out, byte and parity latched
// SEND  | single-cycle Send pulse to the transmitter
// WAIT  | frame window, counter runs down to zero
// DONE  | frame_done pulse, busy drops on the next edge
module tx_frame_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 8,
    parameter int FRAME_CYC  = 11,
    parameter int ODD_PARITY = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    tx_frame_scheduler_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(FRAME_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_SEND,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_parity_q, tx_parity_d;
    logic                tx_send_q, tx_send_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;

    logic                sel_found;
    logic [ID_W-1:0]     sel_idx;
    logic [ID_W-1:0]     cand;
    logic [DATA_W-1:0]   sel_data;

    // Search starts one past the last winner so the last winner gets lowest priority.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!sel_found && bus.req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
        sel_data = bus.req_data[sel_idx*DATA_W +: DATA_W];
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        ack_d        = ack_q;
        grant_id_d   = grant_id_q;
        tx_data_d    = tx_data_q;
        tx_parity_d  = tx_parity_q;
        tx_send_d    = tx_send_q;
        busy_d       = busy_q;
        frame_done_d = frame_done_q;

        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    ack_d          = '0;
                    ack_d[sel_idx] = 1'b1;
                    grant_id_d     = sel_idx;
                    tx_data_d      = sel_data;
                    tx_parity_d    = (^sel_data) ^ 1'(ODD_PARITY);
                    busy_d         = 1'b1;
                    state_d        = S_GRANT;
                end
            end
            S_GRANT: begin
                ack_d     = '0;
                tx_send_d = 1'b1;
                cnt_d     = CNT_W'(FRAME_CYC - 1);
                state_d   = S_SEND;
            end
            S_SEND: begin
                tx_send_d = 1'b0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    frame_done_d = 1'b1;
                    ptr_d        = grant_id_q;
                    state_d      = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                frame_done_d = 1'b0;
                busy_d       = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ptr_q        <= ID_W'(NUM_REQ - 1);
            ack_q        <= '0;
            grant_id_q   <= '0;
            tx_data_q    <= '0;
            tx_parity_q  <= 1'b0;
            tx_send_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            ack_q        <= ack_d;
            grant_id_q   <= grant_id_d;
            tx_data_q    <= tx_data_d;
            tx_parity_q  <= tx_parity_d;
            tx_send_q    <= tx_send_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.ack        = ack_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_parity  = tx_parity_q;
    assign bus.tx_send    = tx_send_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Scoreboard bench for tx_frame_scheduler: stimulus queues expected grants,
// a negedge monitor pops them on each Ack and tracks the frame timing that follows.
module tb_tx_frame_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tx_frame_scheduler_if #(.NUM_REQ(4), .DATA_W(8)) ifa ();
    tx_frame_scheduler_if #(.NUM_REQ(4), .DATA_W(8)) ifb ();

    tx_frame_scheduler #(.NUM_REQ(4), .DATA_W(8), .FRAME_CYC(11), .ODD_PARITY(0)) dut_even (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    tx_frame_scheduler #(.NUM_REQ(4), .DATA_W(8), .FRAME_CYC(11), .ODD_PARITY(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    typedef struct {
        int         id;
        logic [7:0] data;
        logic       par;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit pend[2];
    int ack_cyc[2];
    exp_t cur[2];
    int last_send[2];
    bit period_chk = 1'b0;

    logic [3:0] ack_v[2];
    logic [1:0] gid_v[2];
    logic [7:0] dat_v[2];
    logic       par_v[2];
    logic       send_v[2];
    logic       busy_v[2];
    logic       done_v[2];

    assign ack_v[0] = ifa.ack;        assign ack_v[1] = ifb.ack;
    assign gid_v[0] = ifa.grant_id;   assign gid_v[1] = ifb.grant_id;
    assign dat_v[0] = ifa.tx_data;    assign dat_v[1] = ifb.tx_data;
    assign par_v[0] = ifa.tx_parity;  assign par_v[1] = ifb.tx_parity;
    assign send_v[0] = ifa.tx_send;   assign send_v[1] = ifb.tx_send;
    assign busy_v[0] = ifa.busy;      assign busy_v[1] = ifb.busy;
    assign done_v[0] = ifa.frame_done; assign done_v[1] = ifb.frame_done;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int d, input int id, input logic [7:0] data, input logic par);
        exp_t e;
        e.id = id; e.data = data; e.par = par;
        if (d == 0) qa.push_back(e); else qb.push_back(e);
    endtask

    task automatic mon_step(input int d);
        exp_t e;
        int off;
        if (!rst_n) begin
            pend[d] = 1'b0;
            return;
        end
        if (send_v[d] && period_chk) begin
            if (last_send[d] >= 0) chk("send_period", cyc - last_send[d], 15);
            last_send[d] = cyc;
        end
        if (ack_v[d] != 4'b0) begin
            chk("ack_onehot", int'($onehot(ack_v[d])), 1);
            if ((d == 0 ? qa.size() : qb.size()) == 0) begin
                chk("unexpected_ack", int'(ack_v[d]), 0);
            end else begin
                e = (d == 0) ? qa.pop_front() : qb.pop_front();
                cur[d] = e;
                chk("ack_vec", int'(ack_v[d]), 1 << e.id);
                chk("grant_id", int'(gid_v[d]), e.id);
                chk("tx_data", int'(dat_v[d]), int'(e.data));
                chk("tx_parity", int'(par_v[d]), int'(e.par));
                chk("busy_at_ack", int'(busy_v[d]), 1);
                ack_cyc[d] = cyc;
                pend[d] = 1'b1;
            end
        end else if (pend[d]) begin
            off = cyc - ack_cyc[d];
            chk("tx_send_timing", int'(send_v[d]), (off == 1) ? 1 : 0);
            chk("frame_done_timing", int'(done_v[d]), (off == 13) ? 1 : 0);
            chk("busy_window", int'(busy_v[d]), (off <= 13) ? 1 : 0);
            chk("tx_data_hold", int'(dat_v[d]), int'(cur[d].data));
            chk("grant_id_hold", int'(gid_v[d]), cur[d].id);
            if (off >= 14) pend[d] = 1'b0;
        end else begin
            chk("idle_send", int'(send_v[d]), 0);
            chk("idle_done", int'(done_v[d]), 0);
            chk("idle_busy", int'(busy_v[d]), 0);
        end
    endtask

    always @(negedge clk) begin
        mon_step(0);
        mon_step(1);
    end

    task automatic chk_zero(input int d, input string tag);
        chk({tag, "_ack"}, int'(ack_v[d]), 0);
        chk({tag, "_gid"}, int'(gid_v[d]), 0);
        chk({tag, "_data"}, int'(dat_v[d]), 0);
        chk({tag, "_par"}, int'(par_v[d]), 0);
        chk({tag, "_send"}, int'(send_v[d]), 0);
        chk({tag, "_busy"}, int'(busy_v[d]), 0);
        chk({tag, "_done"}, int'(done_v[d]), 0);
    endtask

    task automatic wait_ack(input int d, input int i, input bit clr);
        bit seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (ack_v[d][i]) seen = 1'b1;
        end
        if (!seen) chk("ack_timeout", i, -1);
        else if (clr) begin
            if (d == 0) ifa.req[i] = 1'b0; else ifb.req[i] = 1'b0;
        end
    endtask

    task automatic wait_idle(input int d);
        bit idle = 1'b0;
        for (int n = 0; n < 60 && !idle; n++) begin
            @(negedge clk);
            if (!busy_v[d]) idle = 1'b1;
        end
        if (!idle) chk("busy_timeout", 1, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        ifa.req = '0; ifa.req_data = '0;
        ifb.req = '0; ifb.req_data = '0;
        last_send[0] = -1; last_send[1] = -1;
        repeat (3) @(negedge clk);
        chk_zero(0, "rst_a");
        chk_zero(1, "rst_b");
        rst_n = 1'b1;
        @(negedge clk);

        // single request, even parity
        ifa.req_data[7:0] = 8'hA5;
        push(0, 0, 8'hA5, 1'b0);
        ifa.req = 4'b0001;
        wait_ack(0, 0, 1'b1);
        wait_idle(0);

        // odd parity instance
        ifb.req_data[7:0] = 8'h07;
        push(1, 0, 8'h07, 1'b0);
        ifb.req = 4'b0001;
        wait_ack(1, 0, 1'b1);
        wait_idle(1);
        ifb.req_data[7:0] = 8'h03;
        push(1, 0, 8'h03, 1'b1);
        ifb.req = 4'b0001;
        wait_ack(1, 0, 1'b1);
        wait_idle(1);

        // all requesters held: rotation 0,1,2,3,0 and 15-cycle Send spacing
        pulse_reset();
        ifa.req_data = {8'h3D, 8'hC3, 8'h5B, 8'h81};
        push(0, 0, 8'h81, 1'b0);
        push(0, 1, 8'h5B, 1'b1);
        push(0, 2, 8'hC3, 1'b0);
        push(0, 3, 8'h3D, 1'b1);
        push(0, 0, 8'h81, 1'b0);
        last_send[0] = -1;
        period_chk = 1'b1;
        ifa.req = 4'b1111;
        wait_ack(0, 0, 1'b0);
        wait_ack(0, 1, 1'b0);
        wait_ack(0, 2, 1'b0);
        wait_ack(0, 3, 1'b0);
        wait_ack(0, 0, 1'b0);
        ifa.req = 4'b0000;
        wait_idle(0);
        period_chk = 1'b0;

        // late requests during the frame of requester 2
        pulse_reset();
        ifa.req_data = {8'h37, 8'h70, 8'h11, 8'h00};
        push(0, 2, 8'h70, 1'b1);
        push(0, 3, 8'h37, 1'b1);
        push(0, 1, 8'h11, 1'b0);
        ifa.req = 4'b0100;
        wait_ack(0, 2, 1'b1);
        repeat (4) @(negedge clk);
        ifa.req[1] = 1'b1;
        ifa.req[3] = 1'b1;
        wait_ack(0, 3, 1'b1);
        wait_ack(0, 1, 1'b1);
        wait_idle(0);

        // asynchronous reset in the middle of WAIT
        ifa.req_data[7:0] = 8'hA5;
        push(0, 0, 8'hA5, 1'b0);
        ifa.req = 4'b0001;
        wait_ack(0, 0, 1'b1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero(0, "midrst_a");
        chk_zero(1, "midrst_b");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ifa.req_data[31:24] = 8'hE1;
        push(0, 3, 8'hE1, 1'b0);
        ifa.req = 4'b1000;
        wait_ack(0, 3, 1'b1);
        wait_idle(0);

        // one-cycle request while busy must be ignored
        ifa.req_data[7:0] = 8'h3C;
        push(0, 0, 8'h3C, 1'b0);
        ifa.req = 4'b0001;
        wait_ack(0, 0, 1'b1);
        repeat (3) @(negedge clk);
        ifa.req_data[15:8] = 8'hFF;
        ifa.req[1] = 1'b1;
        @(negedge clk);
        ifa.req[1] = 1'b0;
        wait_idle(0);
        repeat (20) @(negedge clk);
        chk("pulse_busy_final", int'(busy_v[0]), 0);

        chk("queue_a_empty", qa.size(), 0);
        chk("queue_b_empty", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
